// File: rtl/instruction_decoder.sv
// Decode stage: splits the instruction into fields, reads operands from a 16x32 register file
// with writeback bypass, and produces execute/memory/writeback stage controls.
module instruction_decoder #(
  parameter int unsigned bus = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    instruction,
  input  logic [bus-1:0] WBd,
  input  logic [bus-1:0] PCi,
  input  logic [3:0]     RDwb,
  input  logic           WE,
  output logic [bus-1:0] OPA,
  output logic [bus-1:0] OPB,
  output logic [bus-1:0] STR_DATA,
  output logic [bus-1:0] PCo,
  output logic [bus-1:0] RKo,
  output logic [3:0]     RDo,
  output logic [1:0]     FUNTYPE,
  output logic [1:0]     FUNCODE,
  output logic           selWB,
  output logic           selMEMRD,
  output logic           selMEMWR,
  output logic           selCACHEWR,
  output logic           selCACHESH,
  output logic           selBRANCH
);

  logic [bus-1:0] regs_q [16];

  logic [1:0]     funtype;
  logic [1:0]     funcode;
  logic [3:0]     ra;
  logic [3:0]     rb;
  logic [3:0]     rd;
  logic [14:0]    imm;
  logic           imm_sel;
  logic [bus-1:0] imm_ext;
  logic [bus-1:0] rdata_a;
  logic [bus-1:0] rdata_b;
  logic [bus-1:0] rdata_d;

  assign funtype = instruction[31:30];
  assign funcode = instruction[29:28];
  assign ra      = instruction[27:24];
  assign rb      = instruction[23:20];
  assign rd      = instruction[19:16];
  assign imm     = instruction[15:1];
  assign imm_sel = instruction[0];
  assign imm_ext = {{(bus - 15){imm[14]}}, imm};

  // Reset loads each register with its own index.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 16; n++) begin
        regs_q[n] <= bus'(n);
      end
    end else if (WE) begin
      regs_q[RDwb] <= WBd;
    end
  end

  // Same-cycle writeback bypass on every read port.
  always_comb begin
    rdata_a = (WE && (RDwb == ra)) ? WBd : regs_q[ra];
    rdata_b = (WE && (RDwb == rb)) ? WBd : regs_q[rb];
    rdata_d = (WE && (RDwb == rd)) ? WBd : regs_q[rd];
  end

  always_comb begin
    OPA      = rdata_a;
    OPB      = imm_sel ? imm_ext : rdata_b;
    STR_DATA = rdata_d;
    RKo      = imm_ext;
    RDo      = rd;
    PCo      = PCi;
    FUNTYPE  = funtype;
    FUNCODE  = funcode;
  end

  always_comb begin
    selWB      = 1'b0;
    selMEMRD   = 1'b0;
    selMEMWR   = 1'b0;
    selCACHEWR = 1'b0;
    selCACHESH = 1'b0;
    selBRANCH  = 1'b0;
    unique case (funtype)
      2'b00: selWB = 1'b1;
      2'b01: begin
        unique case (funcode)
          2'b00: begin
            selMEMRD = 1'b1;
            selWB    = 1'b1;
          end
          2'b01:   selMEMWR   = 1'b1;
          2'b10:   selCACHEWR = 1'b1;
          default: selCACHESH = 1'b1;
        endcase
      end
      2'b10:   selBRANCH = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Scoreboard bench for instruction_decoder: a driver pushes model predictions, a monitor pops
// and compares them against the DUT half a cycle later.
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] WBd;
  logic [31:0] PCi;
  logic [3:0]  RDwb;
  logic        WE;
  logic [31:0] OPA, OPB, STR_DATA, PCo, RKo;
  logic [3:0]  RDo;
  logic [1:0]  FUNTYPE, FUNCODE;
  logic        selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH;

  instruction_decoder #(.bus(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .WBd(WBd), .PCi(PCi), .RDwb(RDwb),
    .WE(WE), .OPA(OPA), .OPB(OPB), .STR_DATA(STR_DATA), .PCo(PCo), .RKo(RKo), .RDo(RDo),
    .FUNTYPE(FUNTYPE), .FUNCODE(FUNCODE), .selWB(selWB), .selMEMRD(selMEMRD),
    .selMEMWR(selMEMWR), .selCACHEWR(selCACHEWR), .selCACHESH(selCACHESH),
    .selBRANCH(selBRANCH)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] opa, opb, str, pco, rko;
    logic [3:0]  rdo;
    logic [1:0]  ft, fc;
    logic [5:0]  sels;  // {wb, memrd, memwr, cachewr, cacheshare, branch}
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;

  // Reference register file, updated from the inputs that were present at each edge.
  logic [31:0] model_regs [16];
  logic        prev_rst = 1'b1;
  logic        prev_we = 1'b0;
  logic [3:0]  prev_rdwb = 4'd0;
  logic [31:0] prev_wbd = 32'd0;

  function automatic logic [31:0] mk(input int ft, input int fc, input int ra, input int rb,
                                     input int rd, input int imm, input int i);
    return (32'(ft) << 30) | (32'(fc) << 28) | (32'(ra) << 24) | (32'(rb) << 20) |
           (32'(rd) << 16) | (32'(imm & 32'h7fff) << 1) | 32'(i & 1);
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (WE && int'(RDwb) == a) return WBd;
    return model_regs[a];
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] wbd, input logic [31:0] pci,
                       input logic [3:0] rdwb, input logic we, input logic r, input bit chk);
    exp_t e;
    int   ft, fc, imm;
    logic [31:0] sx;
    @(posedge clk);
    #1;
    if (prev_rst) begin
      for (int n = 0; n < 16; n++) model_regs[n] = 32'(n);
    end else if (prev_we) begin
      model_regs[prev_rdwb] = prev_wbd;
    end
    instruction = ins; WBd = wbd; PCi = pci; RDwb = rdwb; WE = we; rst = r;
    prev_rst = r; prev_we = we; prev_rdwb = rdwb; prev_wbd = wbd;
    if (chk) begin
      ft  = int'(ins[31:30]);
      fc  = int'(ins[29:28]);
      imm = int'(ins[15:1]);
      sx  = (imm >= 16384) ? 32'(imm - 32768) : 32'(imm);
      e.opa  = model_read(int'(ins[27:24]));
      e.opb  = ins[0] ? sx : model_read(int'(ins[23:20]));
      e.str  = model_read(int'(ins[19:16]));
      e.pco  = pci;
      e.rko  = sx;
      e.rdo  = ins[19:16];
      e.ft   = ins[31:30];
      e.fc   = ins[29:28];
      e.sels = {ft == 0 || (ft == 1 && fc == 0), ft == 1 && fc == 0, ft == 1 && fc == 1,
                ft == 1 && fc == 2, ft == 1 && fc == 3, ft == 2};
      exp_q.push_back(e);
    end
  endtask

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: outputs are combinational, so each issued instruction is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("OPA", OPA, e.opa);
      cmp("OPB", OPB, e.opb);
      cmp("STR_DATA", STR_DATA, e.str);
      cmp("PCo", PCo, e.pco);
      cmp("RKo", RKo, e.rko);
      cmp("RDo", 32'(RDo), 32'(e.rdo));
      cmp("FUNTYPE", 32'(FUNTYPE), 32'(e.ft));
      cmp("FUNCODE", 32'(FUNCODE), 32'(e.fc));
      cmp("selects", 32'({selWB, selMEMRD, selMEMWR, selCACHEWR, selCACHESH, selBRANCH}),
          32'(e.sels));
    end
  end

  initial begin
    rst = 1'b1; WE = 1'b0; RDwb = 4'd0; WBd = 32'd0; PCi = 32'd0; instruction = 32'd0;
    drive(32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    drive(32'h0122_0000, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);       // ADD R1,R2 -> R2
    drive(mk(0, 0, 1, 2, 3, 16'h7fff, 1), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(0, 1, 1, 2, 3, 5, 1), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(0, 0, 8, 2, 3, 0, 0), 32'd3, 32'd0, 4'd8, 1'b1, 1'b0, 1'b1);  // bypass
    drive(mk(0, 0, 8, 8, 8, 0, 0), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 0, 1, 2, 3, 4, 1), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 1, 1, 2, 4, 0, 0), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 2, 5, 6, 7, 0, 0), 32'd0, 32'h0000_000c, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(1, 3, 5, 6, 7, 0, 0), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(2, 2, 9, 10, 11, 16'h4000, 0), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    drive(mk(3, 1, 8, 8, 8, 0, 0), 32'd0, 32'd0, 4'd0, 1'b0, 1'b1, 1'b1);  // rst mid-stream
    drive(mk(0, 0, 8, 8, 8, 0, 0), 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b1);  // R8 back to 8
    for (int k = 0; k < 400; k++) begin
      drive($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 31) == 0), 1'b1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
